// File: rtl/alarm_event_decoder_if.sv
// Event channel between the alarm decoder and its consumer:
// a head event is presented by valid and taken with ready.
interface alarm_event_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [5:0] evt_len;
  logic       evt_err;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_len,
    output evt_err,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_len,
    input  evt_err,
    output evt_ready
  );
endinterface

// File: rtl/alarm_event_decoder.sv
// Measures buzzer pulses, classifies each one as an event and queues the events
// in a first-word-fall-through FIFO for a ready/valid consumer.
module alarm_event_decoder #(
  parameter int EXP_LEN = 31,
  parameter int LEN_TOL = 2,
  parameter int DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [2:0]            buz_in,
  alarm_event_decoder_if.master ev,
  output logic [7:0]            evt_total,
  output logic                  ovf
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LEN_LO = EXP_LEN - LEN_TOL;
  localparam int LEN_HI = EXP_LEN + LEN_TOL;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEASURE  = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  localparam logic [5:0]  LEN_MAX  = 6'd63;
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

  logic [1:0] state, state_nx;
  logic [2:0] hot, hot_nx;
  logic [5:0] len, len_nx;

  logic       push;
  logic [8:0] push_data;

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [AW:0] occ;
  logic        empty, full, pop, accept;
  logic [8:0]  head;

  function automatic logic [1:0] chan_of(input logic [2:0] pat);
    logic [1:0] c;
    c = 2'd0;
    case (pat)
      3'b001:  c = 2'd1;
      3'b010:  c = 2'd2;
      3'b100:  c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  function automatic logic len_bad(input logic [5:0] l);
    return (int'(l) < LEN_LO) || (int'(l) > LEN_HI);
  endfunction

  // Event word layout: {code[1:0], len[5:0], err}
  always_comb begin
    state_nx  = state;
    hot_nx    = hot;
    len_nx    = len;
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        if (buz_in != 3'b000) begin
          if ($onehot(buz_in)) begin
            hot_nx   = buz_in;
            len_nx   = 6'd1;
            state_nx = MEASURE;
          end else begin
            push      = 1'b1;
            push_data = {2'd0, 6'd1, 1'b1};
            len_nx    = '0;
            state_nx  = WAIT_LOW;
          end
        end
      end
      MEASURE: begin
        if (buz_in == hot) begin
          len_nx = (len == LEN_MAX) ? len : len + 6'd1;
        end else if (buz_in == 3'b000) begin
          push      = 1'b1;
          push_data = {chan_of(hot), len, len_bad(len)};
          len_nx    = '0;
          state_nx  = IDLE;
        end else begin
          push      = 1'b1;
          push_data = {chan_of(hot), len, 1'b1};
          len_nx    = '0;
          state_nx  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (buz_in == 3'b000) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        len_nx   = '0;
      end
    endcase
  end

  assign occ    = wptr - rptr;
  assign empty  = (wptr == rptr);
  assign full   = (occ == OCC_FULL);
  assign pop    = ena && !empty && ev.evt_ready;
  // A pop in the same cycle frees the slot the push needs when full.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hot       <= '0;
      len       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      evt_total <= '0;
      ovf       <= 1'b0;
    end else if (ena) begin
      state <= state_nx;
      hot   <= hot_nx;
      len   <= len_nx;
      if (accept) begin
        wptr      <= wptr + 1'b1;
        evt_total <= evt_total + 8'd1;
      end
      if (push && !accept) ovf <= 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ena && accept) mem[wptr[AW-1:0]] <= push_data;
  end

  assign head         = mem[rptr[AW-1:0]];
  assign ev.evt_valid = !empty;
  assign ev.evt_code  = empty ? '0 : head[8:7];
  assign ev.evt_len   = empty ? '0 : head[6:1];
  assign ev.evt_err   = empty ? 1'b0 : head[0];

endmodule

// File: tb/tb_alarm_event_decoder.sv
// Randomized and directed bench for alarm_event_decoder, checked every cycle
// against a pulse/segment-level model of the event stream.
module tb_alarm_event_decoder;

  localparam int EXP_LEN = 31;
  localparam int LEN_TOL = 2;
  localparam int DEPTH   = 4;

  typedef struct {
    int code;
    int len;
    int err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [2:0] buz;
  logic [7:0] evt_total;
  logic       ovf;

  alarm_event_decoder_if bus ();

  alarm_event_decoder #(
    .EXP_LEN (EXP_LEN),
    .LEN_TOL (LEN_TOL),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .buz_in    (buz),
    .ev        (bus),
    .evt_total (evt_total),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit armed      = 0;
  int vcycles    = 0;

  ev_t q[$];
  ev_t popped[$];
  int  m_total = 0;
  bit  m_ovf   = 0;

  // A segment is a run of non-zero samples bounded by zeros or reset.
  bit         seg_on     = 0;
  bit         seg_broken = 0;
  logic [2:0] seg_pat    = '0;
  int         seg_len    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int chan(input logic [2:0] p);
    return (p == 3'b001) ? 1 : (p == 3'b010) ? 2 : (p == 3'b100) ? 3 : 0;
  endfunction

  function automatic ev_t mk(input int code, input int l, input bit forced);
    ev_t e;
    int  ls;
    ls     = (l > 63) ? 63 : l;
    e.code = code;
    e.len  = ls;
    e.err  = (forced || ls < EXP_LEN - LEN_TOL || ls > EXP_LEN + LEN_TOL) ? 1 : 0;
    return e;
  endfunction

  always @(posedge clk) begin
    ev_t e;
    bit  have;
    bit  do_pop;
    have = 0;
    e    = '{0, 0, 0};
    if (rst) begin
      q.delete();
      m_total    = 0;
      m_ovf      = 0;
      seg_on     = 0;
      seg_broken = 0;
      seg_len    = 0;
    end else if (ena) begin
      do_pop = (q.size() != 0) && bus.evt_ready;
      if (buz == 3'b000) begin
        if (seg_on && !seg_broken) begin
          e    = mk(chan(seg_pat), seg_len, 0);
          have = 1;
        end
        seg_on     = 0;
        seg_broken = 0;
      end else if (!seg_on) begin
        seg_on = 1;
        if ($countones(buz) == 1) begin
          seg_pat    = buz;
          seg_len    = 1;
          seg_broken = 0;
        end else begin
          e          = mk(0, 1, 1);
          have       = 1;
          seg_broken = 1;
        end
      end else if (!seg_broken) begin
        if (buz == seg_pat) seg_len++;
        else begin
          e          = mk(chan(seg_pat), seg_len, 1);
          have       = 1;
          seg_broken = 1;
        end
      end
      if (do_pop) popped.push_back(q.pop_front());
      if (have) begin
        if (q.size() < DEPTH) begin
          q.push_back(e);
          m_total = (m_total + 1) % 256;
        end else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", int'(bus.evt_valid), int'(q.size() != 0));
      chk("code",  int'(bus.evt_code),  (q.size() != 0) ? q[0].code : 0);
      chk("len",   int'(bus.evt_len),   (q.size() != 0) ? q[0].len  : 0);
      chk("err",   int'(bus.evt_err),   (q.size() != 0) ? q[0].err  : 0);
      chk("total", int'(evt_total),     m_total);
      chk("ovf",   int'(ovf),           int'(m_ovf));
      if (bus.evt_valid) vcycles++;
    end
  end

  task automatic cyc(input logic [2:0] b, input int n);
    repeat (n) begin
      buz = b;
      @(negedge clk);
    end
  endtask

  task automatic rcyc(input logic [2:0] b, input int n);
    repeat (n) begin
      buz           = b;
      bus.evt_ready = ($urandom_range(0, 1) == 1);
      ena           = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3'b000, 2);
    rst = 1'b0;
  endtask

  task automatic chk_ev(input string nm, input int idx, input int c, input int l, input int e);
    if (idx < popped.size()) begin
      chk({nm, "_code"}, popped[idx].code, c);
      chk({nm, "_len"},  popped[idx].len,  l);
      chk({nm, "_err"},  popped[idx].err,  e);
    end else chk({nm, "_present"}, popped.size(), idx + 1);
  endtask

  logic [2:0] multi_tab [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    rst           = 1'b1;
    ena           = 1'b1;
    buz           = 3'b000;
    bus.evt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    armed = 1;
    chk("rst_valid", int'(bus.evt_valid), 0);
    chk("rst_total", int'(evt_total), 0);

    // Nominal pulse drains immediately.
    bus.evt_ready = 1'b1;
    popped.delete();
    vcycles = 0;
    cyc(3'b001, 31);
    cyc(3'b000, 4);
    chk("nom_count", popped.size(), 1);
    chk_ev("nom", 0, 1, 31, 0);
    chk("nom_vcycles", vcycles, 1);
    chk("nom_total", int'(evt_total), 1);

    popped.delete();
    cyc(3'b010, 20);
    cyc(3'b000, 3);
    cyc(3'b100, 33);
    cyc(3'b000, 3);
    chk("two_count", popped.size(), 2);
    chk_ev("short", 0, 2, 20, 1);
    chk_ev("edge33", 1, 3, 33, 0);

    popped.delete();
    cyc(3'b011, 5);
    cyc(3'b000, 3);
    cyc(3'b001, 31);
    cyc(3'b000, 3);
    chk("multi_count", popped.size(), 2);
    chk_ev("multi", 0, 0, 1, 1);
    chk_ev("after_multi", 1, 1, 31, 0);

    // Overflow with a stalled consumer, then drain.
    do_reset();
    bus.evt_ready = 1'b0;
    repeat (5) begin
      cyc(3'b001, 31);
      cyc(3'b000, 2);
    end
    chk("ovf_total", int'(evt_total), 4);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_valid", int'(bus.evt_valid), 1);
    popped.delete();
    bus.evt_ready = 1'b1;
    cyc(3'b000, 6);
    chk("ovf_drain", popped.size(), 4);
    chk_ev("ovf_last", 3, 1, 31, 0);

    // Push and pop on the same edge while full.
    do_reset();
    bus.evt_ready = 1'b0;
    repeat (4) begin
      cyc(3'b001, 31);
      cyc(3'b000, 2);
    end
    cyc(3'b010, 31);
    bus.evt_ready = 1'b1;
    cyc(3'b000, 1);
    bus.evt_ready = 1'b0;
    cyc(3'b000, 2);
    chk("pp_total", int'(evt_total), 5);
    chk("pp_ovf", int'(ovf), 0);
    popped.delete();
    bus.evt_ready = 1'b1;
    cyc(3'b000, 6);
    chk("pp_drain", popped.size(), 4);
    chk_ev("pp_last", 3, 2, 31, 0);

    // Saturation, then reset in the middle of a pulse.
    popped.delete();
    cyc(3'b001, 70);
    cyc(3'b000, 3);
    chk_ev("sat", 0, 1, 63, 1);
    popped.delete();
    cyc(3'b001, 9);
    rst = 1'b1;
    cyc(3'b001, 1);
    rst = 1'b0;
    cyc(3'b001, 30);
    cyc(3'b000, 3);
    chk("midrst_count", popped.size(), 1);
    chk_ev("midrst", 0, 1, 30, 0);

    // Random pulses with random ready, enable and occasional reset.
    repeat (80) begin
      int         kind;
      logic [2:0] a;
      logic [2:0] b;
      kind = $urandom_range(0, 9);
      a    = 3'b001 << $urandom_range(0, 2);
      if (kind < 6) rcyc(a, $urandom_range(1, 40));
      else if (kind < 8) rcyc(multi_tab[$urandom_range(0, 3)], $urandom_range(1, 6));
      else begin
        b = 3'b001 << $urandom_range(0, 2);
        if (b == a) b = multi_tab[$urandom_range(0, 3)];
        rcyc(a, $urandom_range(1, 35));
        rcyc(b, $urandom_range(1, 4));
      end
      rcyc(3'b000, $urandom_range(1, 5));
    end

    rst           = 1'b0;
    ena           = 1'b1;
    bus.evt_ready = 1'b1;
    cyc(3'b000, 10);
    chk("final_empty", int'(bus.evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alarm_event_decoder.md
ALARM_EVENT_DECODER -- requirements
Module: alarm_event_decoder

Interface
REQ-001 Parameter EXP_LEN, default 31: nominal buzzer pulse width in clk cycles.
REQ-002 Parameter LEN_TOL, default 2: permitted +/- deviation from EXP_LEN.
REQ-003 Parameter DEPTH, default 4: event FIFO depth; SHALL be a power of two, 2..16.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 ena  input  1  when low, all state, FIFO contents and outputs hold.
REQ-007 buz_in  input  3  buzzer lines from the alarm block; bit0=buzzer1, bit1=buzzer2, bit2=buzzer3; synchronous to clk.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_valid  output  1  FIFO non-empty; head event is presented.
REQ-010 evt_code  output  2  head event channel: 1/2/3 for buzzer1/2/3; 0 for a multi-hot fault.
REQ-011 evt_len  output  6  head event pulse length in cycles, saturating at 63.
REQ-012 evt_err  output  1  head event is malformed: length out of tolerance, or the pattern was not one-hot.
REQ-013 evt_total  output  8  count of events pushed; wraps 255->0.
REQ-014 ovf  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-015 FSM states SHALL be IDLE, MEASURE and WAIT_LOW.
REQ-016 IDLE:
- buz_in==0 -> stay in IDLE.
- buz_in one-hot -> latch channel, len=1, go to MEASURE.
- buz_in multi-hot -> push {code 0, len 1, err 1}, go to WAIT_LOW.
REQ-017 MEASURE:
- buz_in equal to the latched one-hot value -> len=len+1, saturating at 63.
- buz_in==0 -> push {channel, len, err}, go to IDLE.
- err = (len < EXP_LEN-LEN_TOL) or (len > EXP_LEN+LEN_TOL).
REQ-018 MEASURE, any other non-zero buz_in -> push {latched channel, len, err 1}, go to WAIT_LOW.
REQ-019 WAIT_LOW SHALL return to IDLE on the first cycle with buz_in==0, and SHALL push nothing.
REQ-020 Push latency: the event SHALL be written on the edge that samples the terminating buz_in value; evt_valid SHALL rise on the next cycle if the FIFO was empty.
REQ-021 Handshake:
- Pop occurs when evt_valid && evt_ready.
- Head outputs SHALL remain stable while evt_valid && !evt_ready.
REQ-022 FIFO is first-word-fall-through; evt_code/len/err are undefined-free and SHALL read 0 while empty.
REQ-023 Push while full and no pop in the same cycle -> drop the event, set ovf, do not increment evt_total.
REQ-024 Push and pop in the same cycle while full -> both are accepted and occupancy is unchanged.
REQ-025 Push and pop in the same cycle while empty is impossible; evt_valid is low, so no pop occurs.
REQ-026 evt_total SHALL increment once per accepted push.
REQ-027 Pointers and occupancy SHALL wrap modulo DEPTH and 2*DEPTH respectively.

Reset
REQ-028 rst=1 on a clk edge, regardless of ena, SHALL produce:
- State IDLE, len=0, FIFO empty.
- evt_valid=0, evt_code=0, evt_len=0, evt_err=0, evt_total=0, ovf=0.
REQ-029 Reset mid-pulse SHALL discard the partial measurement.
- If buz_in is still high after reset releases, the FSM SHALL start a fresh measurement at len=1.

Verification
REQ-030 buz_in=3'b001 for 31 cycles, then 0; evt_ready=1 -> one event {code1, len31, err0} with evt_valid high for 1 cycle; evt_total=1.
REQ-031 buz_in=3'b010 for 20 cycles -> {code2, len20, err1}; buz_in=3'b100 for 33 cycles -> {code3, len33, err0}.
REQ-032 buz_in=3'b011 for 5 cycles -> exactly one event {code0, len1, err1}; the state returns to IDLE after buz_in=0.
REQ-033 evt_ready=0, five valid 31-cycle pulses -> 4 events held in order; ovf=1 and evt_total=4; then evt_ready=1 drains all 4 in order.
REQ-034 buz_in=3'b001 held for 70 cycles -> evt_len=63, err1; rst pulsed at cycle 10 of a pulse held 40 cycles in total -> a single event with len30.
REQ-035 Full FIFO with a simultaneous push and pop -> occupancy stays at 4, ovf unchanged, evt_total increments.
